// File: rtl/m_timer_sequencer.sv
// Control FSM for a BCD kitchen timer. It steers an external min:sec counter chain
// and drives the alarm buzzer.
module m_timer_sequencer #(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_stop,
  input  logic        btn_sec,
  input  logic        btn_min,
  input  logic [15:0] time_in,
  output logic        mode,
  output logic        clken,
  output logic        cb_sec,
  output logic        cb_min,
  output logic        buzzer,
  output logic        running,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam logic [7:0] ALARM_LIMIT = 8'(ALARM_SEC);

  state_t     fsm;
  logic [7:0] alarm_cnt;
  logic       zero;

  assign zero  = (time_in == 16'h0000);
  assign state = fsm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      mode      <= 1'b0;
      clken     <= 1'b0;
      cb_sec    <= 1'b0;
      cb_min    <= 1'b0;
      buzzer    <= 1'b0;
      running   <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      cb_sec <= 1'b0;
      cb_min <= 1'b0;
      unique case (fsm)
        IDLE: begin
          // An accepted start outranks any same-cycle set buttons.
          if (btn_start && !btn_stop && !zero) begin
            fsm     <= RUN;
            mode    <= 1'b1;
            clken   <= 1'b1;
            running <= 1'b1;
          end else begin
            cb_sec <= btn_sec;
            cb_min <= btn_min;
          end
        end
        RUN: begin
          if (btn_stop) begin
            fsm     <= IDLE;
            mode    <= 1'b0;
            clken   <= 1'b0;
            running <= 1'b0;
          end else if (btn_start) begin
            fsm     <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            // At 00:00 the tick raises the alarm instead of borrowing to 99:59.
            if (zero) begin
              fsm       <= ALARM;
              mode      <= 1'b0;
              clken     <= 1'b0;
              running   <= 1'b0;
              buzzer    <= 1'b1;
              alarm_cnt <= 8'd0;
            end else begin
              cb_sec <= 1'b1;
            end
          end
        end
        PAUSE: begin
          if (btn_stop) begin
            fsm   <= IDLE;
            mode  <= 1'b0;
            clken <= 1'b0;
          end else if (btn_start) begin
            fsm     <= RUN;
            running <= 1'b1;
          end
        end
        ALARM: begin
          if (btn_stop || btn_start) begin
            fsm    <= IDLE;
            buzzer <= 1'b0;
          end else if (tick) begin
            alarm_cnt <= alarm_cnt + 8'd1;
            if (alarm_cnt + 8'd1 == ALARM_LIMIT) begin
              fsm    <= IDLE;
              buzzer <= 1'b0;
            end else begin
              buzzer <= ~buzzer;
            end
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_timer_sequencer.sv
// Bench for m_timer_sequencer: directed scenarios, then random button/tick traffic.
// A behavioural min:sec counter chain feeds time_in back to the DUT.
module tb_m_timer_sequencer;

  localparam int ALARM_N = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0, btn_start = 1'b0, btn_stop = 1'b0, btn_sec = 1'b0, btn_min = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic        mode, clken, cb_sec, cb_min, buzzer, running;
  logic [1:0]  state;

  m_timer_sequencer #(.ALARM_SEC(ALARM_N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_start(btn_start), .btn_stop(btn_stop),
    .btn_sec(btn_sec), .btn_min(btn_min), .time_in(time_in), .mode(mode), .clken(clken),
    .cb_sec(cb_sec), .cb_min(cb_min), .buzzer(buzzer), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Counter chain model: plain minutes/seconds integers.
  int ch_min = 0, ch_sec = 0;

  // Reference model: phase of the timer plus alarm ticks heard so far.
  int m_phase = 0;      // 0 idle, 1 running, 2 paused, 3 alarm
  int m_ticks = 0;
  bit e_cs = 0, e_cm = 0;
  bit last_tick = 0;

  function automatic logic [15:0] to_bcd(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", name, obs, exp, $time);
  endtask

  task automatic check_all(input string tag);
    bit counting;
    counting = (m_phase == 1) || (m_phase == 2);
    check({tag, ".state"},   8'(state),   8'(m_phase));
    check({tag, ".mode"},    8'(mode),    8'(counting));
    check({tag, ".clken"},   8'(clken),   8'(counting));
    check({tag, ".running"}, 8'(running), 8'(m_phase == 1));
    check({tag, ".cb_sec"},  8'(cb_sec),  8'(e_cs));
    check({tag, ".cb_min"},  8'(cb_min),  8'(e_cm));
    // Buzzer is on for every even number of alarm ticks heard.
    check({tag, ".buzzer"},  8'(buzzer),  8'((m_phase == 3) && (m_ticks % 2 == 0)));
  endtask

  task automatic step(input bit t, input bit st, input bit sp, input bit bs, input bit bm,
                      input string tag);
    bit zero, p_cs, p_cm, p_mode;
    @(negedge clk);
    tick = t; btn_start = st; btn_stop = sp; btn_sec = bs; btn_min = bm;
    zero = (ch_min == 0) && (ch_sec == 0);
    e_cs = 0; e_cm = 0;
    if (m_phase == 0) begin
      if (st && !sp && !zero) m_phase = 1;
      else begin e_cs = bs; e_cm = bm; end
    end else if (m_phase == 1) begin
      if (sp) m_phase = 0;
      else if (st) m_phase = 2;
      else if (t && zero) begin m_phase = 3; m_ticks = 0; end
      else if (t) e_cs = 1;
    end else if (m_phase == 2) begin
      if (sp) m_phase = 0;
      else if (st) m_phase = 1;
    end else begin
      if (sp || st) m_phase = 0;
      else if (t) begin
        m_ticks++;
        if (m_ticks == ALARM_N) m_phase = 0;
      end
    end
    p_cs = cb_sec; p_cm = cb_min; p_mode = mode;
    @(posedge clk);
    #1;
    // The chain counts the pulse that was present at this edge.
    if (p_cs) begin
      if (!p_mode) ch_sec = (ch_sec + 1) % 60;
      else if (ch_sec > 0) ch_sec--;
      else if (ch_min > 0) begin ch_min--; ch_sec = 59; end
    end
    if (p_cm) ch_min = (ch_min + 1) % 100;
    time_in = to_bcd(ch_min, ch_sec);
    last_tick = t;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    @(negedge clk);
    tick = 0; btn_start = 0; btn_stop = 0; btn_sec = 0; btn_min = 0;
    #1 reset = 1'b1;
    #1;
    m_phase = 0; m_ticks = 0; e_cs = 0; e_cm = 0;
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1;
    check_all("por");
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    step(0, 0, 0, 0, 0, "idle");
    // Start at 00:00 is ignored.
    step(0, 1, 0, 0, 0, "start_zero");
    // Set 00:02, run it down to the alarm.
    step(0, 0, 0, 1, 0, "set_s1");
    step(0, 0, 0, 0, 0, "gap");
    step(0, 0, 0, 1, 0, "set_s2");
    step(0, 0, 0, 0, 0, "gap");
    step(0, 1, 0, 0, 0, "run");
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, "run_tick");
      step(0, 0, 0, 0, 0, "run_gap");
    end
    for (int i = 0; i < ALARM_N; i++) begin
      step(1, 0, 0, 0, 0, "alarm_tick");
      step(0, 0, 0, 0, 0, "alarm_gap");
    end
    step(0, 1, 0, 0, 0, "start_after_alarm");
    // Set 02:03 and then both buttons together.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, "set_sec");
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, "set_min");
    step(0, 0, 0, 0, 0, "gap");
    step(0, 0, 0, 1, 1, "set_both");
    step(0, 1, 0, 0, 0, "run2");
    step(1, 1, 0, 0, 0, "tick_and_pause");
    step(1, 0, 0, 1, 1, "pause_tick");
    step(0, 1, 0, 0, 0, "resume");
    step(1, 0, 0, 0, 0, "run_tick2");
    step(0, 1, 1, 0, 0, "start_stop");
    step(0, 1, 0, 0, 0, "run3");
    step(1, 0, 0, 0, 0, "run_tick3");
    mid_reset("reset_mid_run");
    step(0, 0, 0, 0, 0, "post_reset");

    for (int i = 0; i < 600; i++) begin
      bit t, st, sp, bs, bm;
      t  = !last_tick && ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 23) == 0);
      bs = !sp && ($urandom_range(0, 3) == 0);
      bm = !sp && ($urandom_range(0, 9) == 0);
      if (i % 150 == 149) mid_reset("rand_reset");
      else step(t, st, sp, bs, bm, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/m_timer_sequencer.md
M_TIMER_SEQUENCER -- requirements
Module: m_timer_sequencer

Interface
REQ-001 Parameter ALARM_SEC, default 10, number of tick periods the alarm sounds before auto-stopping (range 1..255).
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick  input  1  one-cycle 1 Hz enable pulse.
REQ-005 btn_start  input  1  one-cycle debounced pulse; start/pause/resume.
REQ-006 btn_stop  input  1  one-cycle debounced pulse; stop/abort/silence.
REQ-007 btn_sec  input  1  one-cycle pulse; increment seconds while setting.
REQ-008 btn_min  input  1  one-cycle pulse; increment minutes while setting.
REQ-009 time_in  input  16  BCD time from the counter chain, {min_hi, min_lo, sec_hi, sec_lo}.
REQ-010 mode  output  1  counter-chain direction; 0 = up/set, 1 = down.
REQ-011 clken  output  1  counter-chain down-count enable.
REQ-012 cb_sec  output  1  one-cycle carry/borrow pulse into the seconds-ones counter.
REQ-013 cb_min  output  1  one-cycle carry pulse into the minutes-ones counter.
REQ-014 buzzer  output  1  alarm drive.
REQ-015 running  output  1  high only in RUN.
REQ-016 state  output  2  IDLE=0, RUN=1, PAUSE=2, ALARM=3.

Function
REQ-017 All outputs SHALL be registered; every response SHALL appear exactly one clk after the causing input cycle.
REQ-018 States IDLE, RUN, PAUSE, ALARM; mode=1 and clken=1 in RUN and PAUSE; mode=0 and clken=0 in IDLE and ALARM.
REQ-019 zero SHALL be defined combinationally as time_in==16'h0000.
REQ-020 IDLE: btn_sec -> cb_sec pulse; btn_min -> cb_min pulse; btn_start with zero=0 -> RUN; btn_start with zero=1 ignored.
REQ-021 IDLE priority: btn_start (when accepted) over btn_sec/btn_min; btn_sec and btn_min together SHALL produce both pulses in the same cycle.
REQ-022 RUN: tick with zero=0 -> cb_sec pulse (decrement); tick with zero=1 -> ALARM, no cb_sec pulse (no wrap to 99:59).
REQ-023 RUN: btn_start -> PAUSE; btn_stop -> IDLE; both SHALL take priority over a same-cycle tick, which is then dropped.
REQ-024 RUN/PAUSE: btn_sec and btn_min SHALL be ignored; cb_min SHALL never pulse outside IDLE.
REQ-025 PAUSE: btn_start -> RUN; btn_stop -> IDLE; tick ignored; time_in retained.
REQ-026 btn_start and btn_stop in the same cycle: btn_stop wins in every state.
REQ-027 ALARM entry SHALL clear an 8-bit tick counter and set buzzer=1; each tick toggles buzzer and increments the counter.
REQ-028 ALARM SHALL exit to IDLE, buzzer=0, on the tick that brings the counter to ALARM_SEC, or immediately on btn_start or btn_stop.
REQ-029 Leaving ALARM via IDLE SHALL leave time_in at 00:00, so a subsequent btn_start is ignored until the time is set.
REQ-030 Entering IDLE from any state with mode=0 SHALL NOT generate cb_sec or cb_min.

Reset
REQ-031 reset=1 SHALL immediately force state=IDLE, mode=0, clken=0, cb_sec=0, cb_min=0, buzzer=0, running=0, alarm counter=0, regardless of clk.
REQ-032 Reset asserted mid-RUN or mid-ALARM SHALL abort without any pending cb_sec pulse; first post-release edge obeys IDLE rules.

Verification
REQ-033 Reset, then btn_sec x3, btn_min x2 (time_in model 02:03) -> exactly 3 cb_sec and 2 cb_min one-cycle pulses, mode=0, state=0.
REQ-034 time_in=00:02, btn_start, 3 ticks -> state=1 next cycle, mode=1; cb_sec on ticks 1 and 2; tick 3 -> state=3, buzzer=1, no cb_sec.
REQ-035 ALARM_SEC=4, alarm entered, 4 ticks -> buzzer 1,0,1,0 then state=0, buzzer=0 after 4th tick.
REQ-036 RUN with tick and btn_start in same cycle -> state=2, no cb_sec; later tick in PAUSE -> no pulse; btn_start -> state=1.
REQ-037 time_in=00:00 in IDLE, btn_start -> stays state=0; btn_start+btn_stop in RUN -> state=0.
REQ-038 reset pulsed between clk edges during RUN -> all outputs 0 and state=0 without a clk edge.
